// File: rtl/ram_fifo_ctrl_if.sv
// Signal bundle between the FIFO controller, its stream user and the 64x16
// dual-port RAM. The slave modport is the controller's view; the master
// modport is the surrounding environment (stream user plus RAM read data).
interface ram_fifo_ctrl_if #(
    parameter int width = 64,
    parameter int size  = 4
);
    // Stream side
    logic             flush;
    logic             push;
    logic [width-1:0] push_data;
    logic             pop;
    logic [width-1:0] pop_data;
    logic             pop_valid;
    logic             full;
    logic             empty;
    logic [size:0]    count;
    logic             overflow;
    logic             underflow;

    // RAM side
    logic             ram_wr_en;
    logic [size-1:0]  ram_wr_addr;
    logic [width-1:0] ram_din;
    logic             ram_rd_en;
    logic [size-1:0]  ram_rd_addr;
    logic [width-1:0] ram_dout;

    modport slave (
        input  flush, push, push_data, pop, ram_dout,
        output pop_data, pop_valid, full, empty, count, overflow, underflow,
               ram_wr_en, ram_wr_addr, ram_din, ram_rd_en, ram_rd_addr
    );

    modport master (
        output flush, push, push_data, pop, ram_dout,
        input  pop_data, pop_valid, full, empty, count, overflow, underflow,
               ram_wr_en, ram_wr_addr, ram_din, ram_rd_en, ram_rd_addr
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a dual-port RAM: converts push/pop requests
// into RAM write/read strobes, owns both address pointers and the occupancy
// count, and records rejected pushes/pops in sticky flags.
// depth must equal 2**size; the pointers then wrap naturally at depth.
module ram_fifo_ctrl #(
    parameter int width = 64,
    parameter int depth = 16,
    parameter int size  = 4
) (
    input  logic              clk,
    input  logic              rst,
    ram_fifo_ctrl_if.slave    bus
);
    localparam logic [size:0] depth_c = (size+1)'(depth);

    logic [size-1:0] wptr;
    logic [size-1:0] rptr;
    logic [size:0]   count;
    logic            pop_valid;
    logic            overflow;
    logic            underflow;

    logic            full;
    logic            empty;
    logic            push_acc;
    logic            pop_acc;

    // Status flags decoded from the registered occupancy.
    assign full  = (count == depth_c);
    assign empty = (count == '0);

    // A request is accepted only when it cannot over/underrun and no clear is pending.
    assign push_acc = bus.push & ~full  & ~bus.flush & ~rst;
    assign pop_acc  = bus.pop  & ~empty & ~bus.flush & ~rst;

    // RAM strobes and addresses come straight from acceptance and the pointers.
    assign bus.ram_wr_en   = push_acc;
    assign bus.ram_wr_addr = wptr;
    assign bus.ram_din     = bus.push_data;
    assign bus.ram_rd_en   = pop_acc;
    assign bus.ram_rd_addr = rptr;

    // Read data is the RAM's registered output, qualified by pop_valid.
    assign bus.pop_data  = bus.ram_dout;
    assign bus.pop_valid = pop_valid;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.count     = count;
    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;

    // Pointer, occupancy, read-valid and sticky-flag registers (rst > flush > push/pop).
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // The RAM read issued this cycle returns its word next cycle.
            pop_valid <= pop_acc;

            if (bus.push && full && !bus.flush) begin
                overflow <= 1'b1;
            end
            if (bus.pop && empty && !bus.flush) begin
                underflow <= 1'b1;
            end

            if (bus.flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                wptr  <= wptr + size'(push_acc);
                rptr  <= rptr + size'(pop_acc);
                count <= count + (size+1)'(push_acc) - (size+1)'(pop_acc);
            end
        end
    end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl. A queue-based FIFO model predicts
// occupancy, addresses, read data and sticky flags; a behavioural 64x16 RAM
// sits on the controller's RAM port.
module tb_ram_fifo_ctrl;
    localparam int W = 64;
    localparam int D = 16;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst;

    ram_fifo_ctrl_if #(.width(W), .size(S)) bus ();

    ram_fifo_ctrl #(.width(W), .depth(D), .size(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port RAM: write on edge, registered read.
    logic [W-1:0] mem [D];
    always @(posedge clk) begin
        if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_din;
        if (bus.ram_rd_en) bus.ram_dout <= mem[bus.ram_rd_addr];
    end

    // Reference model state
    logic [W-1:0] q [$];
    int           m_wr, m_rd;
    bit           m_pv, m_ovf, m_unf;
    logic [W-1:0] m_pd;

    int n_checks = 0;
    int n_pass   = 0;

    // One clock cycle: apply inputs, compare all outputs with the model, advance the model.
    task automatic run_cycle(input bit p, input logic [W-1:0] d, input bit o,
                             input bit f, input bit r);
        int n;
        bit fe, ee, pa, oa;
        @(negedge clk);
        rst = r; bus.flush = f; bus.push = p; bus.push_data = d; bus.pop = o;
        #1;
        n  = q.size();
        fe = (n == D);
        ee = (n == 0);
        pa = p && !fe && !f && !r;
        oa = o && !ee && !f && !r;
        n_checks++; if (bus.count !== (S+1)'(n)) $display("FAIL count: got %0d want %0d", bus.count, n); else n_pass++;
        n_checks++; if (bus.full !== fe) $display("FAIL full: got %b want %b", bus.full, fe); else n_pass++;
        n_checks++; if (bus.empty !== ee) $display("FAIL empty: got %b want %b", bus.empty, ee); else n_pass++;
        n_checks++; if (bus.ram_wr_en !== pa) $display("FAIL ram_wr_en: got %b want %b", bus.ram_wr_en, pa); else n_pass++;
        n_checks++; if (bus.ram_rd_en !== oa) $display("FAIL ram_rd_en: got %b want %b", bus.ram_rd_en, oa); else n_pass++;
        n_checks++; if (bus.ram_wr_addr !== S'(m_wr)) $display("FAIL ram_wr_addr: got %0d want %0d", bus.ram_wr_addr, m_wr); else n_pass++;
        n_checks++; if (bus.ram_rd_addr !== S'(m_rd)) $display("FAIL ram_rd_addr: got %0d want %0d", bus.ram_rd_addr, m_rd); else n_pass++;
        n_checks++; if (bus.ram_din !== d) $display("FAIL ram_din: got %h want %h", bus.ram_din, d); else n_pass++;
        n_checks++; if (bus.overflow !== m_ovf) $display("FAIL overflow: got %b want %b", bus.overflow, m_ovf); else n_pass++;
        n_checks++; if (bus.underflow !== m_unf) $display("FAIL underflow: got %b want %b", bus.underflow, m_unf); else n_pass++;
        if (!r) begin
            n_checks++; if (bus.pop_valid !== m_pv) $display("FAIL pop_valid: got %b want %b", bus.pop_valid, m_pv); else n_pass++;
            if (m_pv) begin
                n_checks++; if (bus.pop_data !== m_pd) $display("FAIL pop_data: got %h want %h", bus.pop_data, m_pd); else n_pass++;
            end
        end
        @(posedge clk);
        if (r) begin
            q.delete(); m_wr = 0; m_rd = 0; m_pv = 0; m_ovf = 0; m_unf = 0;
        end else begin
            m_pv = oa;
            if (oa) m_pd = q.pop_front();
            if (pa) q.push_back(d);
            if (p && fe && !f) m_ovf = 1;
            if (o && ee && !f) m_unf = 1;
            if (f) begin
                q.delete(); m_wr = 0; m_rd = 0;
            end else begin
                if (pa) m_wr = (m_wr + 1) % D;
                if (oa) m_rd = (m_rd + 1) % D;
            end
        end
    endtask

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1; bus.flush = 0; bus.push = 0; bus.pop = 0; bus.push_data = '0;
        @(posedge clk);
        q.delete(); m_wr = 0; m_rd = 0; m_pv = 0; m_ovf = 0; m_unf = 0;
        run_cycle(0, '0, 0, 0, 1);
        run_cycle(1, 64'd7, 1, 0, 1);   // requests ignored while rst is high
        run_cycle(0, '0, 0, 0, 0);
        #1;
        n_checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.count !== '0)
            $display("FAIL reset_status: got e=%b f=%b c=%0d want e=1 f=0 c=0", bus.empty, bus.full, bus.count); else n_pass++;
        n_checks++; if (bus.pop_valid !== 1'b0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0)
            $display("FAIL reset_flags: got pv=%b ov=%b un=%b want 0 0 0", bus.pop_valid, bus.overflow, bus.underflow); else n_pass++;
    endtask

    task automatic test_single_word();
        run_cycle(1, 64'd55, 0, 0, 0);
        run_cycle(0, '0, 1, 0, 0);
        run_cycle(0, '0, 0, 0, 0);
        #1;
        n_checks++; if (bus.count !== '0) $display("FAIL single_count: got %0d want 0", bus.count); else n_pass++;
        n_checks++; if (m_pd !== 64'd55) $display("FAIL single_model: got %0d want 55", m_pd); else n_pass++;
    endtask

    task automatic test_fill_wrap();
        for (int i = 0; i < D; i++) run_cycle(1, 64'(i), 0, 0, 0);
        #1;
        n_checks++; if (bus.full !== 1'b1 || bus.count !== 5'd16) $display("FAIL fill_full: got f=%b c=%0d want f=1 c=16", bus.full, bus.count); else n_pass++;
        run_cycle(1, 64'd99, 0, 0, 0);
        run_cycle(0, '0, 0, 0, 0);
        #1;
        n_checks++; if (bus.overflow !== 1'b1) $display("FAIL fill_overflow: got %b want 1", bus.overflow); else n_pass++;
        for (int i = 0; i < D; i++) run_cycle(0, '0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            run_cycle(1, rnd64(), 0, 0, 0);
            run_cycle(0, '0, 1, 0, 0);
        end
        run_cycle(0, '0, 0, 0, 0);
    endtask

    task automatic test_underflow();
        run_cycle(0, '0, 1, 0, 0);
        run_cycle(0, '0, 0, 0, 0);
        #1;
        n_checks++; if (bus.underflow !== 1'b1 || bus.pop_valid !== 1'b0)
            $display("FAIL underflow_flag: got un=%b pv=%b want un=1 pv=0", bus.underflow, bus.pop_valid); else n_pass++;
        run_cycle(1, 64'hBEEF, 1, 0, 0);
        run_cycle(0, '0, 0, 0, 0);
        #1;
        n_checks++; if (bus.count !== 5'd1) $display("FAIL push_pop_empty: got %0d want 1", bus.count); else n_pass++;
        run_cycle(0, '0, 1, 0, 0);
        run_cycle(0, '0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) run_cycle(1, rnd64(), 0, 0, 0);
        for (int i = 0; i < 10; i++) run_cycle(1, rnd64(), 1, 0, 0);
        #1;
        n_checks++; if (bus.count !== 5'd8) $display("FAIL steady_count: got %0d want 8", bus.count); else n_pass++;
        for (int i = 0; i < 8; i++) run_cycle(1, rnd64(), 0, 0, 0);
        run_cycle(1, rnd64(), 1, 0, 0);
        run_cycle(0, '0, 0, 0, 0);
        #1;
        n_checks++; if (bus.count !== 5'd15) $display("FAIL full_push_pop: got %0d want 15", bus.count); else n_pass++;
        while (q.size() > 0) run_cycle(0, '0, 1, 0, 0);
        run_cycle(0, '0, 0, 0, 0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) run_cycle(1, rnd64(), 0, 0, 0);
        run_cycle(0, '0, 1, 0, 0);
        run_cycle(1, rnd64(), 1, 1, 0);   // flush wins; earlier pop still valid here
        run_cycle(0, '0, 0, 0, 0);
        #1;
        n_checks++; if (bus.count !== '0 || bus.empty !== 1'b1 || bus.ram_wr_addr !== '0 || bus.ram_rd_addr !== '0)
            $display("FAIL flush_state: got c=%0d e=%b wa=%0d ra=%0d want 0 1 0 0",
                     bus.count, bus.empty, bus.ram_wr_addr, bus.ram_rd_addr); else n_pass++;
        run_cycle(1, 64'hA5, 0, 0, 0);
        run_cycle(0, '0, 1, 0, 0);
        run_cycle(0, '0, 0, 0, 0);
        #1;
        n_checks++; if (bus.pop_data !== 64'hA5) $display("FAIL flush_readback: got %h want a5", bus.pop_data); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            run_cycle(1'($urandom % 2), rnd64(), 1'($urandom % 2),
                      ($urandom % 40) == 0, ($urandom % 80) == 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_word();
        test_fill_wrap();
        test_underflow();
        test_back_to_back();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Synchronous FIFO controller that acts as the initiator on the dual-port RAM's write/read port pair, turning a push/pop stream interface into RAM write and read strobes with managed addresses. It sits in front of the existing 64x16 dual-port RAM instance, owns both address pointers and the occupancy count, and returns read data with a qualifying valid. Overflow and underflow attempts are rejected and recorded in sticky flags.

## Interface
- width, 64, data word width (matches RAM din/dout)
- depth, 16, RAM entries; must equal 2**size
- size, 4, RAM address width
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous clear of pointers/count, RAM contents untouched
- push  in  1  write request
- push_data  in  width  word to write
- pop  in  1  read request
- pop_data  out  width  read word, equals ram_dout
- pop_valid  out  1  pop_data valid this cycle
- full  out  1  count == depth
- empty  out  1  count == 0
- count  out  size+1  current occupancy, 0..depth
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop attempted while empty
- ram_wr_en  out  1  RAM write enable
- ram_wr_addr  out  size  RAM write address
- ram_din  out  width  RAM write data
- ram_rd_en  out  1  RAM read enable
- ram_rd_addr  out  size  RAM read address
- ram_dout  in  width  RAM read data

## Operation
- RAM contract: write mem[wr_addr]=din at rising edge when wr_en; read registers dout=mem[rd_addr] at rising edge when rd_en; read-during-write to same address returns old data (cannot occur here: reads only target occupied entries).
- Registered state: wptr, rptr (size bits), count (size+1 bits), pop_valid, overflow, underflow.
- full/empty decoded combinationally from registered count.
- push_acc = push & ~full & ~flush & ~rst; pop_acc = pop & ~empty & ~flush & ~rst.
- ram_wr_en = push_acc, ram_wr_addr = wptr, ram_din = push_data (combinational).
- ram_rd_en = pop_acc, ram_rd_addr = rptr (combinational).
- On edge: wptr += push_acc, rptr += pop_acc, both wrap modulo depth (15 -> 0); count += push_acc - pop_acc.
- Push and pop in same cycle, both accepted: count unchanged, both pointers advance.
- Full: push rejected even if pop in same cycle (full is registered state); pop still accepted.
- Empty: pop rejected even if push in same cycle; push accepted.
- overflow set when push & full & ~flush; underflow set when pop & empty & ~flush; cleared only by rst.
- pop_valid next = pop_acc. pop_data = ram_dout passthrough.
- Priority: rst > flush > push/pop.
- flush: wptr, rptr, count <= 0; no RAM strobes in flush cycle; pop_valid for a pop accepted the previous cycle still asserts in the flush cycle.
- rst: wptr, rptr, count, pop_valid, overflow, underflow <= 0; strobes forced low while rst high.

## Timing
- Reset values: count 0, empty 1, full 0, pop_valid 0, overflow 0, underflow 0, ram_wr_en 0, ram_rd_en 0, ram_wr_addr 0, ram_rd_addr 0.
- Write: push_acc high in cycle N -> RAM written at end of N; count/full update in N+1.
- Read latency 1: pop_acc high in cycle N -> pop_valid high and pop_data valid in N+1.
- Back-to-back pops: one word per cycle, pop_valid continuous.
- Word pushed in cycle N is poppable from N+1 (empty deasserts in N+1); earliest pop_data in N+2.
- Reset mid-burst: pop accepted in N with rst in N+1 -> pop_valid 0 in N+1 is not required; pop_valid 0 from N+2; all state cleared at end of N+1.

## Test plan
- Reset: hold rst 2 cycles -> empty=1, full=0, count=0, pop_valid=0, flags 0, strobes low.
- Single word: push 64'd55 -> ram_wr_addr=0, ram_wr_en=1; next cycle pop -> ram_rd_addr=0, following cycle pop_valid=1, pop_data=55, count back to 0.
- Fill/wrap: push 0..15 -> full=1 count=16; push 99 -> rejected, overflow=1; pop 16 -> data 0..15 in order; push/pop 4 more -> addresses wrap 15->0, data intact.
- Underflow: pop while empty -> ram_rd_en=0, pop_valid stays 0, underflow=1; push+pop same cycle on empty -> push accepted, pop rejected, count=1.
- Simultaneous at steady state: count=8, push+pop each cycle for 10 cycles -> count stays 8, FIFO order preserved; at full, push+pop -> pop accepted, push rejected, count=15.
- Flush mid-operation: count=5, pop accepted then flush next cycle -> pop_valid=1 in flush cycle, then count=0, empty=1, pointers 0; subsequent push 64'hA5 reads back 64'hA5.
